// File: rtl/hazard_ctrl_unit_pkg.sv
// rtl/hazard_ctrl_unit_pkg.sv - shared types for the pipeline hazard controller
package hazard_ctrl_unit_pkg;

    // Forwarding mux select driven per EX-stage source operand
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_scoreboard.sv
// rtl/hazard_ctrl_unit_scoreboard.sv - pending-write scoreboard for multi-cycle MDU results
// Ports: set_en/set_rd mark a register pending, clr_en/clr_rd retire it,
// src_rs is looked up into src_pending, busy is the OR of all pending bits.
module reg_scoreboard #(
    parameter int REG_SIZE = 5,
    parameter int NUM_SRC  = 2
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         set_en,
    input  logic [REG_SIZE-1:0]          set_rd,
    input  logic                         clr_en,
    input  logic [REG_SIZE-1:0]          clr_rd,
    input  logic [NUM_SRC*REG_SIZE-1:0]  src_rs,
    output logic [NUM_SRC-1:0]           src_pending,
    output logic                         busy
);

    localparam int NUM_REGS = 2 ** REG_SIZE;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // Clear first, then set, so a start and a completion on the same
    // register in one cycle leave it pending. x0 is never tracked.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != '0)) begin
            pending_nxt[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        src_pending = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_pending[i] = pending[src_rs[i*REG_SIZE +: REG_SIZE]];
        end
    end

    assign busy = |pending;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - operand forwarding, load-use bubbles, memory freeze and MDU scoreboard stalls
// Ports: forwarding inputs (mem_/wb_ regWrite, rd, ex_rs) -> df_mux;
// hazard inputs (id_rs, ex_memRead, mem_access, dmem_ready, MDU signals)
// -> pipeline stall/flush enables; stall_cnt counts pc_stall cycles.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_SIZE     = 5,
    parameter int NUM_SRC      = 2,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         mem_regWrite,
    input  logic                         wb_regWrite,
    input  logic [REG_SIZE-1:0]          mem_rd,
    input  logic [REG_SIZE-1:0]          wb_rd,
    input  logic [NUM_SRC*REG_SIZE-1:0]  ex_rs,
    input  logic [NUM_SRC*REG_SIZE-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]           id_rs_used,
    input  logic                         ex_memRead,
    input  logic [REG_SIZE-1:0]          ex_rd,
    input  logic                         mem_access,
    input  logic                         dmem_ready,
    input  logic                         ex_mdu_start,
    input  logic                         id_mdu_op,
    input  logic                         mdu_done,
    input  logic [REG_SIZE-1:0]          mdu_rd,
    output logic [NUM_SRC*2-1:0]         df_mux,
    output logic                         pc_stall,
    output logic                         ifid_stall,
    output logic                         idex_stall,
    output logic                         exmem_stall,
    output logic                         memwb_stall,
    output logic                         idex_flush,
    output logic [CNT_WIDTH-1:0]         stall_cnt
);

    localparam int BW = 2;

    hazard_state_t        state;
    hazard_state_t        state_nxt;
    logic [BW-1:0]        bub_cnt;
    logic [BW-1:0]        bub_cnt_nxt;
    logic [NUM_SRC*2-1:0] fwd_sel;
    logic [NUM_SRC-1:0]   src_pending;
    logic                 mdu_busy;
    logic                 sb_hazard;
    logic                 lu_hazard;
    logic                 freeze;
    logic                 bubble;

    reg_scoreboard #(
        .REG_SIZE (REG_SIZE),
        .NUM_SRC  (NUM_SRC)
    ) u_scoreboard (
        .clk         (clk),
        .rstN        (rstN),
        .set_en      (ex_mdu_start),
        .set_rd      (ex_rd),
        .clr_en      (mdu_done),
        .clr_rd      (mdu_rd),
        .src_rs      (id_rs),
        .src_pending (src_pending),
        .busy        (mdu_busy)
    );

    // MEM stage holds the younger result, so it wins over WB.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mem_regWrite && (mem_rd != '0) &&
                (mem_rd == ex_rs[i*REG_SIZE +: REG_SIZE])) begin
                fwd_sel[i*2 +: 2] = FWD_MEM;
            end else if (wb_regWrite && (wb_rd != '0) &&
                         (wb_rd == ex_rs[i*REG_SIZE +: REG_SIZE])) begin
                fwd_sel[i*2 +: 2] = FWD_WB;
            end
        end
    end

    always_comb begin
        lu_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (ex_rd == id_rs[i*REG_SIZE +: REG_SIZE])) begin
                lu_hazard = 1'b1;
            end
        end
        if (!ex_memRead || (ex_rd == '0)) begin
            lu_hazard = 1'b0;
        end
    end

    assign sb_hazard = (|(src_pending & id_rs_used)) || (id_mdu_op && mdu_busy);
    assign freeze    = mem_access && !dmem_ready;

    // Freeze overrides everything and holds the bubble counter. On release
    // from a freeze that interrupted a load-use stall, the owed bubbles are
    // resumed; otherwise the release cycle is evaluated like IDLE so a
    // load-use pair that formed during the freeze is still caught.
    always_comb begin
        state_nxt   = state;
        bub_cnt_nxt = bub_cnt;
        bubble      = 1'b0;
        if (freeze) begin
            state_nxt = MEM_WAIT;
        end else if (state == LOAD_STALL) begin
            bubble = 1'b1;
            if (bub_cnt <= BW'(1)) begin
                bub_cnt_nxt = '0;
                state_nxt   = IDLE;
            end else begin
                bub_cnt_nxt = bub_cnt - BW'(1);
            end
        end else if ((state == MEM_WAIT) && (bub_cnt != '0)) begin
            bubble    = 1'b1;
            state_nxt = LOAD_STALL;
        end else begin
            state_nxt = IDLE;
            if (sb_hazard) begin
                bubble = 1'b1;
            end else if (lu_hazard) begin
                bubble = 1'b1;
                if (LOAD_BUBBLES > 1) begin
                    state_nxt   = LOAD_STALL;
                    bub_cnt_nxt = BW'(LOAD_BUBBLES - 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            bub_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_cnt_nxt;
            if (pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Outputs are forced low while reset is asserted.
    assign df_mux      = rstN ? fwd_sel : '0;
    assign pc_stall    = rstN && (freeze || bubble);
    assign ifid_stall  = rstN && (freeze || bubble);
    assign idex_flush  = rstN && bubble;
    assign idex_stall  = rstN && freeze;
    assign exmem_stall = rstN && freeze;
    assign memwb_stall = rstN && freeze;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

    localparam int RS = 5;
    localparam int NS = 2;
    localparam int LB = 2;
    localparam int CW = 6;

    logic            clk;
    logic            rstN;
    logic            mem_regWrite, wb_regWrite;
    logic [RS-1:0]   mem_rd, wb_rd, ex_rd, mdu_rd;
    logic [NS*RS-1:0] ex_rs, id_rs;
    logic [NS-1:0]   id_rs_used;
    logic            ex_memRead, mem_access, dmem_ready;
    logic            ex_mdu_start, id_mdu_op, mdu_done;
    logic [NS*2-1:0] df_mux;
    logic            pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall, idex_flush;
    logic [CW-1:0]   stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl_unit #(
        .REG_SIZE(RS), .NUM_SRC(NS), .LOAD_BUBBLES(LB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rstN(rstN),
        .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_rs(ex_rs), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .ex_mdu_start(ex_mdu_start), .id_mdu_op(id_mdu_op),
        .mdu_done(mdu_done), .mdu_rd(mdu_rd),
        .df_mux(df_mux), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_stall(idex_stall), .exmem_stall(exmem_stall),
        .memwb_stall(memwb_stall), .idex_flush(idex_flush),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NS*2-1:0] df;
        logic pc, ifid, idex, exmem, memwb, flush;
    } exp_t;

    // Model state: which registers await an MDU result, how many bubbles
    // are still owed, whether a memory freeze is in progress, stall count.
    logic [31:0] m_pend;
    int          m_owed;
    bit          m_wait;
    int          m_cnt;
    exp_t        me;
    exp_t        ce;

    function automatic bit sb_now();
        bit r = 0;
        for (int s = 0; s < NS; s++)
            if (id_rs_used[s] && m_pend[id_rs[s*RS +: RS]]) r = 1;
        if (id_mdu_op && (m_pend != 0)) r = 1;
        return r;
    endfunction

    function automatic bit lu_now();
        bit r = 0;
        for (int s = 0; s < NS; s++)
            if (id_rs_used[s] && ex_memRead && ex_rd != 0 && ex_rd == id_rs[s*RS +: RS]) r = 1;
        return r;
    endfunction

    function automatic exp_t model_out();
        exp_t e = '0;
        logic [RS-1:0] r;
        if (!rstN) return e;
        for (int s = 0; s < NS; s++) begin
            r = ex_rs[s*RS +: RS];
            if (mem_regWrite && mem_rd != 0 && mem_rd == r) e.df[s*2 +: 2] = 2'b01;
            else if (wb_regWrite && wb_rd != 0 && wb_rd == r) e.df[s*2 +: 2] = 2'b10;
        end
        if (mem_access && !dmem_ready) begin
            e.pc = 1; e.ifid = 1; e.idex = 1; e.exmem = 1; e.memwb = 1;
        end else if (m_owed > 0 || sb_now() || lu_now()) begin
            e.pc = 1; e.ifid = 1; e.flush = 1;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_pend = 0; m_owed = 0; m_wait = 0; m_cnt = 0;
        end else begin
            me = model_out();
            if (me.pc && m_cnt < (2**CW) - 1) m_cnt = m_cnt + 1;
            if (mem_access && !dmem_ready) m_wait = 1;
            else if (m_wait && m_owed > 0) m_wait = 0;
            else if (m_owed > 0) m_owed = m_owed - 1;
            else begin
                m_wait = 0;
                if (!sb_now() && lu_now()) m_owed = LB - 1;
            end
            if (mdu_done) m_pend[mdu_rd] = 1'b0;
            if (ex_mdu_start && ex_rd != 0) m_pend[ex_rd] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        ce = model_out();
        chk("df_mux", 32'(df_mux), 32'(ce.df));
        chk("pc_stall", 32'(pc_stall), 32'(ce.pc));
        chk("ifid_stall", 32'(ifid_stall), 32'(ce.ifid));
        chk("idex_stall", 32'(idex_stall), 32'(ce.idex));
        chk("exmem_stall", 32'(exmem_stall), 32'(ce.exmem));
        chk("memwb_stall", 32'(memwb_stall), 32'(ce.memwb));
        chk("idex_flush", 32'(idex_flush), 32'(ce.flush));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_regWrite = 0; wb_regWrite = 0; mem_rd = 0; wb_rd = 0; ex_rd = 0; mdu_rd = 0;
        ex_rs = 0; id_rs = 0; id_rs_used = 0; ex_memRead = 0; mem_access = 0;
        dmem_ready = 0; ex_mdu_start = 0; id_mdu_op = 0; mdu_done = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 0;
        clear_inputs();
        cyc(2);
        rstN = 1;
        @(negedge clk);
        chk("lit_reset_cnt", 32'(stall_cnt), 32'd0);
        chk("lit_reset_pc", 32'(pc_stall), 32'd0);

        // Forwarding priority and x0 exclusion
        cyc(1);
        mem_rd = 5; wb_rd = 5; mem_regWrite = 1; wb_regWrite = 1; ex_rs = {5'd5, 5'd5};
        #1 chk("lit_fwd_mem", 32'(df_mux), 32'b0101);
        mem_regWrite = 0;
        #1 chk("lit_fwd_wb", 32'(df_mux), 32'b1010);
        mem_regWrite = 1; mem_rd = 0; wb_rd = 0;
        #1 chk("lit_fwd_x0", 32'(df_mux), 32'b0000);
        mem_rd = 5; wb_rd = 3; ex_rs = {5'd3, 5'd5};
        #1 chk("lit_fwd_mix", 32'(df_mux), 32'b1001);
        cyc(1);
        clear_inputs();

        // Load-use with two bubbles
        cyc(1);
        ex_memRead = 1; ex_rd = 7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
        @(negedge clk) chk("lit_lu_b1", 32'(idex_flush), 32'd1);
        cyc(1);
        ex_memRead = 0; ex_rd = 0;
        @(negedge clk) chk("lit_lu_b2", 32'(pc_stall), 32'd1);
        cyc(1);
        @(negedge clk) chk("lit_lu_done", 32'(pc_stall), 32'd0);
        chk("lit_lu_cnt", 32'(stall_cnt), 32'd2);

        // No hazard: source not used, or load targets x0
        ex_memRead = 1; ex_rd = 7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b10;
        #1 chk("lit_lu_unused", 32'(pc_stall), 32'd0);
        ex_rd = 0; id_rs = 0; id_rs_used = 2'b01;
        #1 chk("lit_lu_x0", 32'(pc_stall), 32'd0);
        cyc(1);
        clear_inputs();

        // Memory freeze, load-use forms mid-wait
        cyc(1);
        mem_access = 1; dmem_ready = 0;
        @(negedge clk) chk("lit_frz_memwb", 32'(memwb_stall), 32'd1);
        chk("lit_frz_flush", 32'(idex_flush), 32'd0);
        cyc(1);
        ex_memRead = 1; ex_rd = 7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
        @(negedge clk) chk("lit_frz_exmem", 32'(exmem_stall), 32'd1);
        cyc(1);
        cyc(1);
        dmem_ready = 1;
        @(negedge clk) chk("lit_frz_release", 32'(memwb_stall), 32'd0);
        chk("lit_frz_lu_b1", 32'(idex_flush), 32'd1);
        cyc(1);
        mem_access = 0; dmem_ready = 0; ex_memRead = 0; ex_rd = 0;
        @(negedge clk) chk("lit_frz_lu_b2", 32'(idex_flush), 32'd1);
        cyc(1);
        @(negedge clk) chk("lit_frz_idle", 32'(pc_stall), 32'd0);
        clear_inputs();

        // Scoreboard
        cyc(1);
        ex_mdu_start = 1; ex_rd = 9;
        cyc(1);
        ex_mdu_start = 0; ex_rd = 0; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        @(negedge clk) chk("lit_sb_stall", 32'(pc_stall), 32'd1);
        cyc(2);
        id_rs_used = 0; id_mdu_op = 1;
        @(negedge clk) chk("lit_sb_mdu_busy", 32'(idex_flush), 32'd1);
        cyc(1);
        id_mdu_op = 0; id_rs_used = 2'b01; mdu_done = 1; mdu_rd = 9;
        @(negedge clk) chk("lit_sb_done_cycle", 32'(pc_stall), 32'd1);
        cyc(1);
        mdu_done = 0; mdu_rd = 0;
        @(negedge clk) chk("lit_sb_release", 32'(pc_stall), 32'd0);
        cyc(1);
        id_rs_used = 0; ex_mdu_start = 1; ex_rd = 9;
        cyc(1);
        mdu_done = 1; mdu_rd = 9;
        cyc(1);
        ex_mdu_start = 0; ex_rd = 0; mdu_done = 0; mdu_rd = 0; id_rs_used = 2'b01;
        @(negedge clk) chk("lit_sb_set_wins", 32'(pc_stall), 32'd1);

        // Reset during LOAD_STALL with x9 pending
        cyc(1);
        ex_memRead = 1; ex_rd = 7; id_rs = {5'd7, 5'd9}; id_rs_used = 2'b10;
        cyc(1);
        #1 rstN = 0;
        #1 chk("lit_rst_pc", 32'(pc_stall), 32'd0);
        chk("lit_rst_flush", 32'(idex_flush), 32'd0);
        chk("lit_rst_cnt", 32'(stall_cnt), 32'd0);
        cyc(1);
        rstN = 1;
        clear_inputs();
        id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        @(negedge clk) chk("lit_rst_sb_empty", 32'(pc_stall), 32'd0);
        chk("lit_rst_cnt_after", 32'(stall_cnt), 32'd0);

        // Saturation of the stall counter
        cyc(1);
        id_rs_used = 0; ex_mdu_start = 1; ex_rd = 9;
        cyc(1);
        ex_mdu_start = 0; ex_rd = 0; id_rs_used = 2'b01;
        cyc(2**CW + 6);
        @(negedge clk) chk("lit_sat_cnt", 32'(stall_cnt), 32'd63);
        chk("lit_sat_model", 32'(m_cnt), 32'd63);
        cyc(1);
        mdu_done = 1; mdu_rd = 9;
        cyc(1);
        clear_inputs();
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Next-generation pipeline hazard controller that adds stall and scoreboard logic to combinational operand forwarding. It drives the EX-stage forwarding mux selects, load-use bubbles of parametrised length, whole-pipeline freeze on a slow data memory, and a register scoreboard for a multi-cycle mul/div unit (MDU). It sits beside the ID/EX/MEM/WB pipeline registers and feeds their stall/flush enables.

Parameters:
REG_SIZE, 5, register index width; register file has 2**REG_SIZE entries, x0 hard-wired zero
NUM_SRC, 2, number of source operands per instruction (rs1, rs2, ...)
LOAD_BUBBLES, 1, bubbles inserted on a load-use hazard; legal 1..3
CNT_WIDTH, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  system clock
rstN  in  1  asynchronous active-low reset
mem_regWrite  in  1  MEM-stage instruction writes rd
wb_regWrite  in  1  WB-stage instruction writes rd
mem_rd, wb_rd  in  REG_SIZE  destination registers in MEM/WB
ex_rs  in  NUM_SRC*REG_SIZE  EX-stage source registers, packed, src 0 in LSBs
id_rs  in  NUM_SRC*REG_SIZE  ID-stage source registers, packed
id_rs_used  in  NUM_SRC  ID-stage source actually read
ex_memRead  in  1  EX-stage instruction is a load
ex_rd  in  REG_SIZE  EX-stage destination
mem_access  in  1  MEM stage holds a load/store
dmem_ready  in  1  data memory completes access this cycle
ex_mdu_start  in  1  EX issues an MDU op (one-cycle pulse)
id_mdu_op  in  1  ID-stage instruction is an MDU op
mdu_done  in  1  MDU result written back this cycle
mdu_rd  in  REG_SIZE  destination of completing MDU op
df_mux  out  NUM_SRC*2  forwarding selects: 00 register file, 01 MEM, 10 WB
pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall  out  1  hold the corresponding register
idex_flush  out  1  insert bubble into ID/EX
stall_cnt  out  CNT_WIDTH  saturating count of cycles with pc_stall=1

Behaviour:
- Reset (rstN low, asynchronous): state IDLE, bubble counter 0, scoreboard cleared, stall_cnt 0; all stall/flush outputs 0, df_mux all 00, forced while rstN is low.
- Forwarding (combinational, each src i): MEM match (mem_regWrite, mem_rd!=0, mem_rd==ex_rs[i]) -> 01; else WB match -> 10; else 00. MEM has priority when both match.
- Scoreboard: pending bit per register. Set on ex_mdu_start with ex_rd!=0. Cleared on mdu_done for mdu_rd. Set and clear on the same register in one cycle -> set wins. mdu_done on a non-pending register is ignored. mdu_busy is the OR of all pending bits.
- sb_hazard: any used id_rs[i] pending, or id_mdu_op with mdu_busy.
- lu_hazard: ex_memRead, ex_rd!=0, ex_rd equals any used id_rs[i].
- FSM states IDLE, LOAD_STALL, MEM_WAIT; priority MEM_WAIT > scoreboard > load-use.
- Any state, mem_access and !dmem_ready: all five stalls = 1, idex_flush = 0, next MEM_WAIT. The bubble counter is held.
- MEM_WAIT: exit on dmem_ready to IDLE, or to LOAD_STALL if the counter is nonzero. The freeze deasserts in the dmem_ready cycle.
- IDLE, sb_hazard: pc_stall = ifid_stall = idex_flush = 1, state stays IDLE. Re-evaluated every cycle until clear.
- IDLE, lu_hazard (no sb_hazard): pc_stall = ifid_stall = idex_flush = 1. If LOAD_BUBBLES>1, go to LOAD_STALL with counter = LOAD_BUBBLES-1.
- LOAD_STALL: same three outputs asserted. Counter decrements each cycle; at 1 -> IDLE. LOAD_BUBBLES=1 never enters LOAD_STALL.
- stall_cnt increments on every cycle with pc_stall=1 and saturates at all-ones.
- df_mux remains valid during stalls. Stall outputs are combinational from state and inputs, so there is zero-cycle latency.

Decomposition:
- Shared package: fwd_sel_t enum (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10), hazard_state_t enum (IDLE, LOAD_STALL, MEM_WAIT).
- One sub-module, reg_scoreboard (pending bits, set/clear, per-source lookup, busy flag), instantiated once.

Test Plan:
- mem_rd=wb_rd=5, both regWrite, ex_rs={5,5} -> df_mux={01,01}. Then mem_regWrite=0 -> {10,10}. Then rd=0 -> {00,00}.
- ex_memRead, ex_rd=7, id_rs[0]=7 used, LOAD_BUBBLES=2 -> pc_stall/ifid_stall/idex_flush high exactly 2 cycles, stall_cnt=2.
- Same as above but id_rs_used[0]=0 -> no stall. ex_rd=0 -> no stall.
- mem_access=1, dmem_ready low 3 cycles -> all five stalls high 3 cycles, idex_flush 0, release in the ready cycle. Load-use arriving mid-wait is bubbled after the freeze.
- ex_mdu_start ex_rd=9; ID reads x9 -> stall until mdu_done mdu_rd=9, released the next cycle. Second id_mdu_op while busy -> stalls. Same-cycle start and done on x9 -> x9 stays pending.
- Assert rstN low during LOAD_STALL with pending x9 -> outputs 0 immediately; after release IDLE, scoreboard empty, stall_cnt 0. Force 2**CNT_WIDTH stall cycles -> stall_cnt saturates.
